// File: rtl/ms_countdown_if.sv
// ms_countdown_if: control and status bundle for the down-counting game timer.
//   load/preset/start/stop : commands from the game logic (master -> slave)
//   q                      : remaining count
//   running/done           : state levels (RUN / DONE)
//   expire                 : one-cycle pulse on reaching zero
//   warn                   : low-time warning while RUN or PAUSE
// There is no valid/ready handshake on this bundle. Each command is a level
// that the timer samples on every rising clock edge, and every status output
// is valid in every cycle.
interface ms_countdown_if #(
  parameter int BIT = 10
);
  logic           load;
  logic [BIT-1:0] preset;
  logic           start;
  logic           stop;
  logic [BIT-1:0] q;
  logic           running;
  logic           done;
  logic           expire;
  logic           warn;

  modport master (
    output load, preset, start, stop,
    input  q, running, done, expire, warn
  );

  modport slave (
    input  load, preset, start, stop,
    output q, running, done, expire, warn
  );
endinterface

// File: rtl/ms_countdown.sv
// ms_countdown: down-counting game timer with pause/resume and expiry flags.
// The timer loads a preset, then decrements once every DIV clocks while in RUN.
// Ports:
//   clk   : system clock, rising edge
//   clr   : synchronous active-high reset (q=N, IDLE)
//   bus   : ms_countdown_if slave (commands in, count/status out)
//   state : debug view of the FSM (0=IDLE 1=RUN 2=PAUSE 3=DONE)
module ms_countdown #(
  parameter int N      = 600,
  parameter int BIT    = 10,
  parameter int DIV    = 50000000,
  parameter int DIVBIT = 26,
  parameter int WARN   = 10
) (
  input  logic         clk,
  input  logic         clr,
  ms_countdown_if.slave bus,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [BIT-1:0]    N_V      = BIT'(N);
  localparam logic [BIT-1:0]    WARN_V   = BIT'(WARN);
  localparam logic [BIT-1:0]    ONE_V    = BIT'(1);
  localparam logic [DIVBIT-1:0] DIV_LAST = DIVBIT'(DIV - 1);

  state_t            st_q, st_d;
  logic [BIT-1:0]    q_q, q_d;
  logic [DIVBIT-1:0] pre_q, pre_d;
  logic              exp_q, exp_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      st_q  <= IDLE;
      q_q   <= N_V;
      pre_q <= '0;
      exp_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      q_q   <= q_d;
      pre_q <= pre_d;
      exp_q <= exp_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    q_d   = q_q;
    pre_d = pre_q;
    exp_d = 1'b0;
    if (bus.load) begin
      // Presets above N saturate so the count never exceeds N.
      q_d   = (bus.preset > N_V) ? N_V : bus.preset;
      pre_d = '0;
      st_d  = IDLE;
    end else begin
      case (st_q)
        IDLE: begin
          // stop outranks start, so start+stop leaves IDLE unchanged.
          if (bus.start && !bus.stop && q_q != '0) begin
            st_d  = RUN;
            pre_d = '0;
          end
        end
        RUN: begin
          // stop outranks a terminal count: the prescaler stays at DIV-1,
          // so the step completes on the first edge after resuming.
          if (bus.stop) begin
            st_d = PAUSE;
          end else if (pre_q == DIV_LAST) begin
            pre_d = '0;
            q_d   = q_q - ONE_V;
            if (q_q == ONE_V) begin
              st_d  = DONE;
              exp_d = 1'b1;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        PAUSE: begin
          if (bus.start && !bus.stop) st_d = RUN;
        end
        default: ;  // DONE: only load or clr leaves
      endcase
    end
  end

  assign bus.q       = q_q;
  assign bus.running = (st_q == RUN);
  assign bus.done    = (st_q == DONE);
  assign bus.expire  = exp_q;
  assign bus.warn    = ((st_q == RUN) || (st_q == PAUSE)) &&
                       (q_q != '0) && (q_q <= WARN_V);
  assign state       = st_q;

endmodule
